// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants for the pipelined core's stage registers.
//   State encoding is {main valid, skid valid} so it can be formed
//   directly from the two slot valid bits.
package pipe_pkg;
    localparam int XLEN     = 64;
    localparam int REGIDX_W = 5;
    localparam int CTRL_W   = 8;

    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b10;
    localparam logic [1:0] ST_TWO   = 2'b11;

    localparam int C_BRANCH   = 0;
    localparam int C_MEMREAD  = 1;
    localparam int C_MEMTOREG = 2;
    localparam int C_MEMWRITE = 3;
    localparam int C_REGWRITE = 4;
    localparam int C_ALUSRC   = 5;
    localparam int C_ALUOP_LO = 6;
    localparam int C_ALUOP_HI = 7;

    localparam int IFID_DATA_W  = 2 * XLEN;
    localparam int IDEX_DATA_W  = 4 * XLEN;
    localparam int EXMEM_DATA_W = 3 * XLEN;
    localparam int MEMWB_DATA_W = 2 * XLEN;

    function automatic logic [1:0] occ_of(input logic [1:0] st);
        return {1'b0, st[1]} + {1'b0, st[0]};
    endfunction
endpackage

// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: valid/ready stream carrying control and payload.
//   valid, ctrl, data : producer -> consumer
//   ready             : consumer -> producer
interface pipe_stage_reg_if
    import pipe_pkg::*;
#(
    parameter int CW = CTRL_W,
    parameter int DW = IDEX_DATA_W
);
    logic          valid;
    logic          ready;
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
    modport master (output valid, ctrl, data, input ready);
    modport slave  (input valid, ctrl, data, output ready);
endinterface

// File: rtl/pipe_slot.sv
// pipe_slot: one valid+ctrl+data register.
//   clk     : clock
//   kill_i  : clears valid, ctrl and data (reset or flush)
//   load_i  : captures ctrl_i/data_i and sets valid
//   drain_i : clears valid and ctrl, data keeps its last value
//   valid_o, ctrl_o, data_o : registered contents
module pipe_slot #(
    parameter int CW = 8,
    parameter int DW = 256
) (
    input  logic          clk,
    input  logic          kill_i,
    input  logic          load_i,
    input  logic          drain_i,
    input  logic [CW-1:0] ctrl_i,
    input  logic [DW-1:0] data_i,
    output logic          valid_o,
    output logic [CW-1:0] ctrl_o,
    output logic [DW-1:0] data_o
);
    logic          valid_q, valid_d;
    logic [CW-1:0] ctrl_q, ctrl_d;
    logic [DW-1:0] data_q, data_d;

    always_comb begin
        valid_d = kill_i ? 1'b0 : load_i ? 1'b1 : drain_i ? 1'b0 : valid_q;
        ctrl_d  = kill_i ? '0 : load_i ? ctrl_i : drain_i ? '0 : ctrl_q;
        data_d  = kill_i ? '0 : load_i ? data_i : data_q;
    end

    always_ff @(posedge clk) begin
        valid_q <= valid_d;
        ctrl_q  <= ctrl_d;
        data_q  <= data_d;
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic pipeline-stage register with optional skid entry.
//   clk, reset  : clock, synchronous active-high reset
//   flush_i     : kills all held entries and drops the current input
//   bubble_i    : suppresses acceptance this cycle
//   up          : upstream stream (slave side)
//   dn          : downstream stream (master side), fully registered
//   occupancy_o : entries held, 0..2
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W  = 8,
    parameter int DATA_W  = 256,
    parameter bit SKID_EN = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush_i,
    input  logic                    bubble_i,
    pipe_stage_reg_if.slave         up,
    pipe_stage_reg_if.master        dn,
    output logic [1:0]              occupancy_o
);
    logic              mv, sv;
    logic [CTRL_W-1:0] mc, sc, m_ctrl_d;
    logic [DATA_W-1:0] md, sd, m_data_d;
    logic [1:0]        st;
    logic              kill, in_fire, out_fire;
    logic              m_load, m_drain, s_load, s_drain;

    always_comb begin
        st       = {mv, sv};
        kill     = reset | flush_i;
        out_fire = mv & dn.ready;
        // With the skid entry, ready depends only on state, so it never
        // forms a combinational path from dn.ready.
        up.ready = SKID_EN ? (!sv | flush_i) : (!mv | dn.ready | flush_i);
        in_fire  = up.valid & up.ready & !bubble_i & !flush_i;
        m_load   = (in_fire & (st == ST_EMPTY | (st == ST_ONE & out_fire)))
                 | (st == ST_TWO & out_fire);
        m_drain  = st == ST_ONE & out_fire & !in_fire;
        s_load   = SKID_EN & in_fire & st == ST_ONE & !out_fire;
        s_drain  = st == ST_TWO & out_fire;
        // Skid is older than any new input, so it refills main first.
        m_ctrl_d = sv ? sc : up.ctrl;
        m_data_d = sv ? sd : up.data;
    end

    pipe_slot #(.CW(CTRL_W), .DW(DATA_W)) u_main (
        .clk     (clk),
        .kill_i  (kill),
        .load_i  (m_load),
        .drain_i (m_drain),
        .ctrl_i  (m_ctrl_d),
        .data_i  (m_data_d),
        .valid_o (mv),
        .ctrl_o  (mc),
        .data_o  (md)
    );

    pipe_slot #(.CW(CTRL_W), .DW(DATA_W)) u_skid (
        .clk     (clk),
        .kill_i  (kill),
        .load_i  (s_load),
        .drain_i (s_drain),
        .ctrl_i  (up.ctrl),
        .data_i  (up.data),
        .valid_o (sv),
        .ctrl_o  (sc),
        .data_o  (sd)
    );

    assign dn.valid    = mv;
    assign dn.ctrl     = mc;
    assign dn.data     = md;
    assign occupancy_o = occ_of(st);
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed checks of the skid and non-skid stage registers.
module tb_pipe_stage_reg;
    logic       clk = 1'b0;
    logic       rst, flush0, bubble0;
    logic       flush1 = 1'b0, bubble1 = 1'b0;
    logic [1:0] occ0, occ1;
    int         checks = 0, errors = 0;
    int         snd, rcv;
    logic       fin, fout;

    always #5 clk = ~clk;

    pipe_stage_reg_if #(.CW(8), .DW(256)) up0 ();
    pipe_stage_reg_if #(.CW(8), .DW(256)) dn0 ();
    pipe_stage_reg_if #(.CW(8), .DW(256)) up1 ();
    pipe_stage_reg_if #(.CW(8), .DW(256)) dn1 ();

    pipe_stage_reg #(.CTRL_W(8), .DATA_W(256), .SKID_EN(1'b1)) u0 (
        .clk(clk), .reset(rst), .flush_i(flush0), .bubble_i(bubble0),
        .up(up0), .dn(dn0), .occupancy_o(occ0)
    );

    pipe_stage_reg #(.CTRL_W(8), .DATA_W(256), .SKID_EN(1'b0)) u1 (
        .clk(clk), .reset(rst), .flush_i(flush1), .bubble_i(bubble1),
        .up(up1), .dn(dn1), .occupancy_o(occ1)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push0(input logic [7:0] c, input logic [255:0] d);
        up0.valid = 1'b1;
        up0.ctrl  = c;
        up0.data  = d;
        tick();
    endtask

    initial begin
        rst = 1'b1; flush0 = 1'b0; bubble0 = 1'b0;
        up0.valid = 1'b0; up0.ctrl = '0; up0.data = '0; dn0.ready = 1'b0;
        up1.valid = 1'b0; up1.ctrl = '0; up1.data = '0; dn1.ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_valid", dn0.valid, 0);
        chk("rst_ctrl", dn0.ctrl, 0);
        chk("rst_data", dn0.data, 0);
        chk("rst_occ", occ0, 0);
        chk("rst_ready", up0.ready, 1);
        chk("rst_valid1", dn1.valid, 0);

        dn0.ready = 1'b1;
        push0(8'h5A, 256'hABCD);
        up0.valid = 1'b0;
        chk("lat_valid", dn0.valid, 1);
        chk("lat_ctrl", dn0.ctrl, 8'h5A);
        chk("lat_data", dn0.data, 256'hABCD);
        chk("lat_occ", occ0, 1);
        tick();
        chk("drain_valid", dn0.valid, 0);
        chk("drain_ctrl", dn0.ctrl, 0);
        chk("drain_data_held", dn0.data, 256'hABCD);

        dn0.ready = 1'b0;
        push0(8'h01, 256'hA);
        chk("bp_occ1", occ0, 1);
        push0(8'h02, 256'hB);
        up0.valid = 1'b0;
        chk("bp_occ2", occ0, 2);
        chk("bp_ready", up0.ready, 0);
        chk("bp_ctrlA", dn0.ctrl, 8'h01);
        tick();
        chk("hold_ctrlA", dn0.ctrl, 8'h01);
        chk("hold_dataA", dn0.data, 256'hA);
        dn0.ready = 1'b1;
        tick();
        chk("bp_ctrlB", dn0.ctrl, 8'h02);
        chk("bp_dataB", dn0.data, 256'hB);
        chk("bp_occB", occ0, 1);
        chk("bp_readyB", up0.ready, 1);
        tick();
        chk("bp_end_valid", dn0.valid, 0);
        chk("bp_end_ctrl", dn0.ctrl, 0);

        dn0.ready = 1'b0;
        push0(8'h11, 256'h11);
        push0(8'h12, 256'h12);
        chk("fl_occ_pre", occ0, 2);
        up0.ctrl = 8'h13; up0.data = 256'hC; flush0 = 1'b1;
        tick();
        flush0 = 1'b0; up0.valid = 1'b0;
        chk("fl_valid", dn0.valid, 0);
        chk("fl_ctrl", dn0.ctrl, 0);
        chk("fl_occ", occ0, 0);
        chk("fl_ready", up0.ready, 1);
        dn0.ready = 1'b1;
        tick(); tick();
        chk("fl_no_C", dn0.valid, 0);

        dn0.ready = 1'b0;
        push0(8'h21, 256'hE);
        chk("bub_pre_ctrl", dn0.ctrl, 8'h21);
        bubble0 = 1'b1; dn0.ready = 1'b1;
        up0.ctrl = 8'h22; up0.data = 256'hD;
        tick();
        chk("bub1_valid", dn0.valid, 0);
        chk("bub1_ctrl", dn0.ctrl, 0);
        tick();
        chk("bub2_valid", dn0.valid, 0);
        chk("bub2_occ", occ0, 0);
        bubble0 = 1'b0;
        tick();
        up0.valid = 1'b0;
        chk("bubD_valid", dn0.valid, 1);
        chk("bubD_ctrl", dn0.ctrl, 8'h22);
        chk("bubD_data", dn0.data, 256'hD);
        tick();
        chk("bubD_nodup", dn0.valid, 0);

        dn0.ready = 1'b0;
        push0(8'h31, 256'h31);
        push0(8'h32, 256'h32);
        up0.valid = 1'b0;
        chk("mr_occ_pre", occ0, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_valid", dn0.valid, 0);
        chk("mr_ctrl", dn0.ctrl, 0);
        chk("mr_data", dn0.data, 0);
        chk("mr_occ", occ0, 0);
        dn0.ready = 1'b1;
        push0(8'h5A, 256'hABCD);
        up0.valid = 1'b0;
        chk("mr_push_valid", dn0.valid, 1);
        chk("mr_push_ctrl", dn0.ctrl, 8'h5A);
        chk("mr_push_data", dn0.data, 256'hABCD);
        chk("mr_push_occ", occ0, 1);

        snd = 0; rcv = 0;
        for (int c = 0; c < 60 && rcv < 10; c++) begin
            dn1.ready = (c % 2 == 0);
            up1.valid = snd < 10;
            up1.ctrl  = 8'(snd + 1);
            up1.data  = 256'(snd + 100);
            #1;
            chk("ns_ready", up1.ready, !dn1.valid | dn1.ready);
            chk("ns_occ_lt2", occ1[1], 0);
            if (!dn1.valid) chk("ns_idle_ctrl", dn1.ctrl, 0);
            fin  = up1.valid & up1.ready;
            fout = dn1.valid & dn1.ready;
            if (fout) begin
                chk("ns_ctrl", dn1.ctrl, 8'(rcv + 1));
                chk("ns_data", dn1.data, 256'(rcv + 100));
                rcv++;
            end
            if (fin) snd++;
            tick();
        end
        up1.valid = 1'b0;
        chk("ns_count", rcv, 10);
        tick(); tick();
        chk("ns_empty", dn1.valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised elastic pipeline-stage register for the pipelined core. It replaces the hard-wired ID/EX-style latches with one reusable block for IF/ID, ID/EX, EX/MEM and MEM/WB.
- Carries a control field and an opaque payload (PC, operands, immediate, register indices, funct fields).
- Adds a valid/ready handshake, an optional 2-entry skid buffer, flush, and bubble insertion.
- Outputs are always registered.

Parameters:
- CTRL_W, 8: width of the control field (Branch, MemRead, MemtoReg, MemWrite, RegWrite, ALUSrc, ALUOp). Forced to zero on bubble, flush, empty and reset.
- DATA_W, 256: width of the payload field. Not cleared except by reset and flush.
- SKID_EN, 1: 1 = two entries with registered in_ready; 0 = single entry with combinational ready pass-through.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- flush  in  1  synchronous kill of all held entries (branch mispredict)
- bubble  in  1  hazard stall: treat in_valid as 0 this cycle
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage can accept
- in_ctrl  in  CTRL_W  upstream control
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  entry presented downstream
- out_ready  in  1  downstream accepts
- out_ctrl  out  CTRL_W  registered control; zero whenever out_valid=0
- out_data  out  DATA_W  registered payload
- occupancy  out  2  entries held, 0..2

Behaviour:
- Definitions:
  - in_fire = in_valid & in_ready & !bubble & !flush
  - out_fire = out_valid & out_ready
- Reset has priority over everything. On reset: out_valid=0, out_ctrl=0, out_data=0, skid cleared, occupancy=0, in_ready=1 from the next cycle.
- Flush is next in priority. Same rules as reset, except in_ready stays 1 during the flush cycle. Input presented in the flush cycle is dropped. out_fire in the flush cycle still counts as consumed downstream.
- Latency: an accepted entry appears on out_* exactly 1 cycle after in_fire when the stage was empty.
- SKID_EN=1 state machine (main valid mv, skid valid sv):
  - EMPTY (0,0):
    - in_fire -> ONE; main loads input.
  - ONE (1,0):
    - in_fire & out_fire -> ONE; main loads input.
    - in_fire & !out_fire -> TWO; skid loads input.
    - !in_fire & out_fire -> EMPTY; out_ctrl <= 0.
    - Otherwise hold.
  - TWO (1,1):
    - out_fire -> ONE; main <= skid.
    - Otherwise hold.
  - in_ready = !sv. It is registered and never depends combinationally on out_ready.
- SKID_EN=0: single entry.
  - in_ready = !out_valid | out_ready (combinational).
  - Simultaneous in_fire and out_fire replaces the entry.
  - occupancy is never 2.
- Bubble:
  - No entry is accepted while bubble is high. In_valid held high across a bubble is accepted on the first cycle bubble is low.
  - If the stage drains during a bubble, out_valid=0 and out_ctrl=0 (a NOP reaches downstream).
  - Bubble never disturbs already-held entries.
- Hold:
  - out_ctrl and out_data are stable while out_valid & !out_ready.
  - No entry is duplicated or reordered. Order is strictly FIFO.
- out_data is not cleared on drain; it holds its last value, which is don't-care while out_valid=0.
- Invariant: occupancy = mv + sv. sv=1 implies mv=1.

Decomposition:
- Shared package pipe_pkg holds:
  - state encoding (ST_EMPTY, ST_ONE, ST_TWO)
  - XLEN=64
  - the control-bit index constants
  - per-boundary payload widths (IDEX_DATA_W etc.), so instantiations agree with decode/execute.
- One natural sub-module: pipe_slot. It is a single valid+ctrl+data register with load/clear inputs, instantiated as main and skid.

Test Plan:
- Reset, then in_valid=1, in_ctrl=8'h5A, in_data=0xABCD, out_ready=1 -> next cycle out_valid=1, out_ctrl=8'h5A, out_data=0xABCD, occupancy=1.
- Back-pressure, SKID_EN=1: push A, B with out_ready=0 -> occupancy=2, in_ready=0, out shows A. Raise out_ready -> A then B on consecutive cycles, then out_valid=0, out_ctrl=0.
- Flush with occupancy=2 and in_valid=1 (entry C) -> next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1; C never emerges.
- Bubble=1 for 2 cycles with in_valid=1 (entry D) and stage draining -> out_valid=0, out_ctrl=0 for those cycles; D emerges 1 cycle after bubble drops; D is not duplicated.
- SKID_EN=0 streaming: 10 entries with out_ready toggling 1,0 -> all 10 received in order; in_ready tracks !out_valid|out_ready in the same cycle.
- Reset asserted mid-stream with occupancy=2 -> all outputs zero the next cycle; the next push behaves as in the first scenario.
